// File: rtl/keyenc.sv
// Keypad encoder: synchronizes and debounces a 12-key pad, queues key codes in a small FIFO.
// Optional auto-repeat of a held key is enabled by defining KEY_REPEAT_EN.
module keyenc #(
    parameter int DEBOUNCE = 4,
    parameter int DEPTH    = 4
) (
    input  logic        ck,
    input  logic        reset,
    input  logic        hz512,
    input  logic        hz32,
    input  logic [11:0] keyin,
    input  logic        rd,
    output logic [3:0]  key,
    output logic        valid,
    output logic        full,
    output logic        ovf
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = AW + 1;
    localparam int DW = $clog2(DEBOUNCE + 1);

    localparam logic [3:0] CLS_NONE    = 4'd12;
    localparam logic [3:0] CLS_INVALID = 4'd13;

    localparam logic ST_IDLE = 1'b0;
    localparam logic ST_HELD = 1'b1;

    logic [11:0]   sync1, sync2;
    logic          hz512_q, s512;
    logic [3:0]    cls, ones, prev_cls;
    logic [DW-1:0] stab_cnt, stab_nxt;
    logic          stable;
    logic          state;
    logic          press_push, release_hit;
    logic          rep_push, push;
    logic [3:0]    push_code;

    logic [3:0]    mem [DEPTH];
    logic [AW-1:0] wptr, rptr;
    logic [CW-1:0] count;
    logic          pop, wr;

    always_ff @(posedge ck) begin
        if (reset) begin
            sync1   <= '0;
            sync2   <= '0;
            hz512_q <= 1'b0;
        end else begin
            sync1   <= keyin;
            sync2   <= sync1;
            hz512_q <= hz512;
        end
    end

    assign s512 = hz512 & ~hz512_q;

    // Single key -> its index, no key -> NONE, several keys -> INVALID.
    always_comb begin
        cls  = CLS_NONE;
        ones = 4'd0;
        for (int i = 0; i < 12; i++) begin
            if (sync2[i]) begin
                ones = ones + 4'd1;
                cls  = 4'(i);
            end
        end
        if (ones > 4'd1) cls = CLS_INVALID;
    end

    always_comb begin
        if (cls != prev_cls)
            stab_nxt = DW'(1);
        else if (stab_cnt == DW'(DEBOUNCE))
            stab_nxt = stab_cnt;
        else
            stab_nxt = stab_cnt + DW'(1);
    end

    assign stable      = s512 && (stab_nxt == DW'(DEBOUNCE));
    assign press_push  = stable && (state == ST_IDLE) && (cls < CLS_NONE);
    assign release_hit = stable && (state == ST_HELD) && (cls == CLS_NONE);

    always_ff @(posedge ck) begin
        if (reset) begin
            prev_cls <= CLS_NONE;
            stab_cnt <= '0;
        end else if (s512) begin
            prev_cls <= cls;
            stab_cnt <= stab_nxt;
        end
    end

    // state | meaning
    // IDLE  | no key accepted; waiting for a stable single key
    // HELD  | key accepted and pushed; waiting for a stable release
    always_ff @(posedge ck) begin
        if (reset)
            state <= ST_IDLE;
        else if (press_push)
            state <= ST_HELD;
        else if (release_hit)
            state <= ST_IDLE;
    end

`ifdef KEY_REPEAT_EN
    logic       hz32_q, s32;
    logic [4:0] rep_cnt;
    logic [3:0] held_code;
    logic       rep_hit;

    assign s32     = hz32 & ~hz32_q;
    assign rep_hit = (rep_cnt == 5'd15);

    // First repeat after 16 s32 ticks, then every 4 (reload to 12).
    always_ff @(posedge ck) begin
        if (reset) begin
            hz32_q    <= 1'b0;
            rep_cnt   <= '0;
            held_code <= '0;
        end else begin
            hz32_q <= hz32;
            if (press_push)
                held_code <= cls;
            if ((state != ST_HELD) || release_hit)
                rep_cnt <= '0;
            else if (s32)
                rep_cnt <= rep_hit ? 5'd12 : rep_cnt + 5'd1;
        end
    end

    assign rep_push  = s32 && (state == ST_HELD) && !release_hit && rep_hit;
    assign push_code = press_push ? cls : held_code;
`else
    logic unused_hz32;
    assign unused_hz32 = hz32;
    assign rep_push    = 1'b0;
    assign push_code   = cls;
`endif

    assign push  = press_push | rep_push;
    assign valid = (count != '0);
    assign full  = (count == CW'(DEPTH));
    assign pop   = rd & valid;
    assign wr    = push & (~full | pop);
    assign key   = valid ? mem[rptr] : 4'd0;

    always_ff @(posedge ck) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
            ovf   <= 1'b0;
        end else begin
            if (wr)
                wptr <= wptr + AW'(1);
            if (pop)
                rptr <= rptr + AW'(1);
            case ({wr, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
            if (push && full && !pop)
                ovf <= 1'b1;
        end
    end

    // Storage is left unreset; contents are hidden while valid is low.
    always_ff @(posedge ck) begin
        if (wr)
            mem[wptr] <= push_code;
    end

endmodule
